// File: rtl/mode_sequencer.sv
// Front-panel mode controller: debounced push-button steps or resets the mode, and the
// selected mode is committed to mode_o only on a vsync rise (or at once when video is lost).
module mode_sequencer #(
    parameter int unsigned NMODES       = 8,
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned DEBOUNCE_T   = 1000000,
    parameter int unsigned LONG_T       = 148500000,
    parameter int unsigned NOSIG_T      = 4000000
) (
    input  logic       vin_clk_i,
    input  logic       rst_ni,
    input  logic       btn_i,
    input  logic       vin_vs_i,
    output logic [2:0] mode_o,
    output logic       pending_o,
    output logic       nosig_o
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_T + 1);
    localparam int unsigned HoldW = $clog2(LONG_T);
    localparam int unsigned NsW   = $clog2(NOSIG_T);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_T - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_T - 1);
    localparam logic [NsW-1:0]   NsLast   = NsW'(NOSIG_T - 1);
    localparam logic [2:0]       LastMode = 3'(NMODES - 1);
    localparam logic [2:0]       DefMode  = 3'(DEFAULT_MODE);

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             btn_meta_q, btn_s_q;
    logic             btn_db_q, btn_db_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [2:0]       pend_mode_q, pend_mode_d;
    logic             pending_q, pending_d;
    logic             vs_r_q;
    logic [NsW-1:0]   ns_cnt_q, ns_cnt_d;

    logic       req;
    logic [2:0] req_mode;
    logic [2:0] base;
    logic       vs_rise;
    logic       nosig;
    logic       commit;

    // Press FSM: state register
    always_ff @(posedge vin_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Press FSM: next state
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (btn_db_q) begin
                    state_d    = StPressed;
                    hold_cnt_d = '0;
                end
            end
            StPressed: begin
                if (!btn_db_q) begin
                    state_d = StIdle;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d = StHeld;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            StHeld: begin
                if (!btn_db_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Press FSM: outputs (mode requests)
    always_comb begin
        req      = 1'b0;
        req_mode = DefMode;
        base     = pending_q ? pend_mode_q : mode_q;
        if (state_q == StPressed) begin
            if (!btn_db_q) begin
                req      = 1'b1;
                req_mode = (base == LastMode) ? 3'd0 : base + 3'd1;
            end else if (hold_cnt_q == HoldLast) begin
                req      = 1'b1;
                req_mode = DefMode;
            end
        end
    end

    always_comb begin
        vs_rise = vin_vs_i & ~vs_r_q;
        nosig   = (ns_cnt_q == NsLast);
        // With no video there is no frame to protect, so commit without waiting.
        commit  = pending_q & (vs_rise | nosig);

        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DbLast) begin
                btn_db_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end

        // A simultaneous request wins over clearing pending; the commit still takes the old value.
        mode_d      = commit ? pend_mode_q : mode_q;
        pend_mode_d = req ? req_mode : pend_mode_q;
        pending_d   = req | (pending_q & ~commit);

        if (vs_rise) begin
            ns_cnt_d = '0;
        end else if (!nosig) begin
            ns_cnt_d = ns_cnt_q + NsW'(1);
        end else begin
            ns_cnt_d = ns_cnt_q;
        end
    end

    always_ff @(posedge vin_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            btn_db_q    <= 1'b0;
            db_cnt_q    <= '0;
            mode_q      <= DefMode;
            pend_mode_q <= DefMode;
            pending_q   <= 1'b0;
            vs_r_q      <= 1'b0;
            ns_cnt_q    <= '0;
        end else begin
            btn_meta_q  <= btn_i;
            btn_s_q     <= btn_meta_q;
            btn_db_q    <= btn_db_d;
            db_cnt_q    <= db_cnt_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pending_q   <= pending_d;
            vs_r_q      <= vin_vs_i;
            ns_cnt_q    <= ns_cnt_d;
        end
    end

    assign mode_o    = mode_q;
    assign pending_o = pending_q;
    assign nosig_o   = nosig;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios plus a randomized run, all checked against
// an event-level reference model of the button/frame rules.
module tb_mode_sequencer;

    localparam int NM  = 8;
    localparam int DEF = 0;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int NOS = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       vs;
    logic [2:0] mode;
    logic       pending;
    logic       nosig;

    int checks = 0;
    int errors = 0;

    bit vs_auto   = 1'b0;
    int vs_period = 40;
    int vs_phase  = 0;

    // Reference model state
    int m_s1, m_s2, m_db, m_run;
    int m_press;  // cycles in the press so far, -1 when no short press is in progress
    int m_long;   // long press already reported, waiting for release
    int m_pend, m_pval, m_mode, m_vsp, m_since;

    mode_sequencer #(
        .NMODES      (NM),
        .DEFAULT_MODE(DEF),
        .DEBOUNCE_T  (DEB),
        .LONG_T      (LNG),
        .NOSIG_T     (NOS)
    ) dut (
        .vin_clk_i(clk),
        .rst_ni   (rst_n),
        .btn_i    (btn),
        .vin_vs_i (vs),
        .mode_o   (mode),
        .pending_o(pending),
        .nosig_o  (nosig)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
        m_press = -1; m_long = 0;
        m_pend = 0; m_pval = DEF; m_mode = DEF; m_vsp = 0; m_since = 0;
    endtask

    task automatic model_step();
        int base, req, rval, rise, commit;
        rise = (vs === 1'b1) && (m_vsp == 0);
        base = (m_pend != 0) ? m_pval : m_mode;
        req  = 0;
        rval = DEF;
        if (m_long != 0) begin
            if (m_db == 0) m_long = 0;
        end else if (m_press < 0) begin
            if (m_db != 0) m_press = 0;
        end else if (m_db != 0) begin
            if (m_press == LNG - 1) begin
                req = 1; rval = DEF; m_long = 1; m_press = -1;
            end else begin
                m_press++;
            end
        end else begin
            req = 1; rval = (base + 1) % NM; m_press = -1;
        end
        commit = (m_pend != 0) && (rise || m_since == NOS - 1);
        if (commit) m_mode = m_pval;
        if (req) begin
            m_pend = 1; m_pval = rval;
        end else if (commit) begin
            m_pend = 0;
        end
        // Accept a new level once the synchronized input has disagreed for DEB cycles in a row.
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run >= DEB) begin
                m_db = m_s2; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = (btn === 1'b1) ? 1 : 0;
        m_since = rise ? 0 : ((m_since < NOS - 1) ? m_since + 1 : m_since);
        m_vsp = (vs === 1'b1) ? 1 : 0;
    endtask

    task automatic tick();
        if (vs_auto) begin
            vs = (vs_phase == 0);
            vs_phase = (vs_phase + 1) % vs_period;
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_press(input int hi, input int lo);
        btn = 1'b1;
        repeat (hi) tick();
        btn = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic reach_mode(input int target);
        for (int n = 0; n < 12 && ((m_pend != 0) ? m_pval : m_mode) != target; n++) begin
            do_press(6, 7);
        end
        for (int k = 0; k < 200 && pending === 1'b1; k++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = 1'b0; vs = 1'b0;
        model_reset();
        #12;
        checks++;
        if (mode !== 3'(DEF) || pending !== 1'b0 || nosig !== 1'b0) begin
            errors++;
            $display("FAIL reset: got mode=%0d pending=%0d nosig=%0d, expected %0d/0/0",
                     mode, pending, nosig, DEF);
        end
        #10 rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (mode !== 3'(DEF) || pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got mode=%0d pending=%0d, expected %0d/0", mode, pending, DEF);
        end
    endtask

    task automatic test_short_press();
        int k;
        vs_auto = 1'b1; vs_period = 40; vs_phase = 20;
        btn = 1'b1;
        repeat (10) tick();
        btn = 1'b0;
        for (k = 0; k < 40 && pending !== 1'b1; k++) tick();
        checks++;
        if (pending !== 1'b1 || mode !== 3'd0) begin
            errors++;
            $display("FAIL short_pending: got pending=%0d mode=%0d, expected 1/0", pending, mode);
        end
        for (k = 0; k < 60 && mode === 3'd0; k++) tick();
        checks++;
        if (mode !== 3'd1 || pending !== 1'b0 || vs !== 1'b1) begin
            errors++;
            $display("FAIL short_commit: got mode=%0d pending=%0d vs=%0d, expected 1/0/1",
                     mode, pending, vs);
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int i = 0; i < 50; i++) begin
            btn = (i < 30) ? (((i / 2) % 2) == 0) : 1'b0;
            tick();
            if (pending !== 1'b0 || mode !== 3'd1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce: got %0d cycles with a request or mode change, expected 0", bad);
        end
    endtask

    task automatic test_wrap();
        int k;
        reach_mode(6);
        checks++;
        if (mode !== 3'd6 || pending !== 1'b0) begin
            errors++;
            $display("FAIL wrap_setup: got mode=%0d pending=%0d, expected 6/0", mode, pending);
        end
        for (k = 0; k < 100 && m_since != 0; k++) tick();
        for (int p = 0; p < 3; p++) begin
            do_press(6, 7);
            checks++;
            if (pending !== 1'b1 || mode !== 3'd6) begin
                errors++;
                $display("FAIL wrap_press%0d: got pending=%0d mode=%0d, expected 1/6",
                         p, pending, mode);
            end
        end
        tick();
        checks++;
        if (mode !== 3'(9 % NM) || pending !== 1'b0) begin
            errors++;
            $display("FAIL wrap_commit: got mode=%0d pending=%0d, expected %0d/0",
                     mode, pending, 9 % NM);
        end
    endtask

    task automatic test_long_press();
        reach_mode(5);
        checks++;
        if (mode !== 3'd5) begin
            errors++;
            $display("FAIL long_setup: got mode=%0d, expected 5", mode);
        end
        btn = 1'b1;
        repeat (26) tick();
        checks++;
        if (mode !== 3'd5 || pending !== 1'b0) begin
            errors++;
            $display("FAIL long_early: got mode=%0d pending=%0d, expected 5/0", mode, pending);
        end
        tick();
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL long_request: got pending=%0d, expected 1", pending);
        end
        repeat (13) tick();
        btn = 1'b0;
        repeat (60) tick();
        checks++;
        if (mode !== 3'(DEF) || pending !== 1'b0) begin
            errors++;
            $display("FAIL long_commit: got mode=%0d pending=%0d, expected %0d/0", mode, pending, DEF);
        end
    endtask

    task automatic test_collision();
        vs_auto = 1'b0; vs = 1'b0; btn = 1'b0;
        #3 rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
        do_press(8, 8);
        do_press(8, 8);
        vs = 1'b1; tick(); vs = 1'b0;
        checks++;
        if (mode !== 3'd2 || pending !== 1'b0) begin
            errors++;
            $display("FAIL collide_setup: got mode=%0d pending=%0d, expected 2/0", mode, pending);
        end
        do_press(8, 8);
        btn = 1'b1;
        repeat (8) tick();
        btn = 1'b0;
        repeat (6) tick();
        vs = 1'b1; tick(); vs = 1'b0;
        checks++;
        if (mode !== 3'd3 || pending !== 1'b1) begin
            errors++;
            $display("FAIL collide_edge: got mode=%0d pending=%0d, expected 3/1", mode, pending);
        end
        tick();
        vs = 1'b1; tick(); vs = 1'b0;
        checks++;
        if (mode !== 3'd4 || pending !== 1'b0) begin
            errors++;
            $display("FAIL collide_next: got mode=%0d pending=%0d, expected 4/0", mode, pending);
        end
    endtask

    task automatic test_nosig();
        int k;
        repeat (NOS - 2) tick();
        checks++;
        if (nosig !== 1'b0) begin
            errors++;
            $display("FAIL nosig_early: got %0d, expected 0", nosig);
        end
        tick();
        checks++;
        if (nosig !== 1'b1) begin
            errors++;
            $display("FAIL nosig_set: got %0d, expected 1", nosig);
        end
        btn = 1'b1;
        repeat (8) tick();
        btn = 1'b0;
        for (k = 0; k < 20 && pending !== 1'b1; k++) tick();
        checks++;
        if (pending !== 1'b1 || mode !== 3'd4) begin
            errors++;
            $display("FAIL nosig_pending: got pending=%0d mode=%0d, expected 1/4", pending, mode);
        end
        tick();
        checks++;
        if (pending !== 1'b0 || mode !== 3'd5) begin
            errors++;
            $display("FAIL nosig_commit: got pending=%0d mode=%0d, expected 0/5", pending, mode);
        end
        vs = 1'b1; tick(); vs = 1'b0;
        checks++;
        if (nosig !== 1'b0) begin
            errors++;
            $display("FAIL nosig_clear: got %0d, expected 0", nosig);
        end
    endtask

    task automatic test_reset_mid_press();
        btn = 1'b1;
        repeat (10) tick();
        checks++;
        if (mode !== 3'd5) begin
            errors++;
            $display("FAIL midrst_before: got mode=%0d, expected 5", mode);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (mode !== 3'(DEF) || pending !== 1'b0 || nosig !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got mode=%0d pending=%0d nosig=%0d, expected %0d/0/0",
                     mode, pending, nosig, DEF);
        end
        btn = 1'b0;
        #2 rst_n = 1'b1;
        vs_auto = 1'b1; vs_period = 40; vs_phase = 5;
        repeat (60) tick();
        checks++;
        if (mode !== 3'(DEF) || pending !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: got mode=%0d pending=%0d, expected %0d/0", mode, pending, DEF);
        end
    endtask

    task automatic test_random();
        int hold_left = 0;
        int r;
        for (int i = 0; i < 3000; i++) begin
            if (hold_left == 0) begin
                btn = ~btn;
                r = $urandom_range(0, 9);
                hold_left = (r < 3) ? $urandom_range(1, 3) :
                            (r < 8) ? $urandom_range(5, 16) : $urandom_range(22, 40);
            end
            hold_left--;
            if (i % 400 == 0) begin
                vs_auto   = ($urandom_range(0, 3) != 0);
                vs_period = $urandom_range(25, 60);
                vs_phase  = vs_phase % vs_period;
                if (!vs_auto) vs = 1'b0;
            end
            tick();
            checks++;
            if (mode !== 3'(m_mode) || pending !== (m_pend != 0) || nosig !== (m_since == NOS - 1))
            begin
                errors++;
                if (errors < 20)
                    $display("FAIL random cycle %0d: got mode=%0d pending=%0d nosig=%0d, expected %0d/%0d/%0d",
                             i, mode, pending, nosig, m_mode, m_pend, m_since == NOS - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_bounce();
        test_wrap();
        test_long_press();
        test_collision();
        test_nosig();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
